uart_echo_master: RTL and testbench
===================================

# uart_echo_master

Hardwired port-bus initiator that replaces the soft processor in front of the UART core. It services the UART interrupt, reads the status and data ports, buffers received bytes in a small FIFO, echoes them back through the transmit data port, and mirrors activity to the LED port. It drives the same port_id / strobe / interrupt_ack handshake the processor would.

## Interface
Parameters:
- DEPTH, 4, echo FIFO depth in bytes; power of two, minimum 2
- DATA_PORT, 16'h0000, port for RX data read and TX data write
- STAT_PORT, 16'h0001, port for status read and LED write
- IDLE_PORT, 16'h00FF, port_id value driven when no access is in progress

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- interrupt  in  1  level from UART interrupt flop; held until acknowledged
- in_port  in  16  read data; [7:0] = {3'b0, OVF, FERR, PERR, TXRDY, RXRDY} on STAT_PORT, RX byte on DATA_PORT
- port_id  out  16  access address
- out_port  out  16  write data
- read_strobe  out  1  one-cycle read qualifier
- write_strobe  out  1  one-cycle write qualifier
- interrupt_ack  out  1  one-cycle acknowledge pulse
- err_cnt  out  8  saturating count of bytes received with PERR, FERR or OVF set
- drop_cnt  out  8  saturating count of bytes dropped on FIFO full

## Operation
- FSM states: IDLE, ACK, RD_STAT, RD_DATA, WR_LED, WR_TX.
- IDLE: port_id=IDLE_PORT, strobes 0. interrupt=1 -> ACK.
- ACK: interrupt_ack=1 -> RD_STAT.
- RD_STAT: port_id=STAT_PORT, read_strobe=1, latch in_port[7:0] into stat. Next: stat[0] -> RD_DATA; else stat[1] and FIFO non-empty -> WR_TX; else IDLE.
- RD_DATA: port_id=DATA_PORT, read_strobe=1 (clears RXRDY in UART), capture in_port[7:0] as last_byte. Push if not full, else drop_cnt+1. If any of stat[4:2] set, err_cnt+1. Next -> WR_LED.
- WR_LED: port_id=STAT_PORT, write_strobe=1, out_port={err_cnt, last_byte}. Next: stat[1] and FIFO non-empty (including the byte just pushed) -> WR_TX; else IDLE.
- WR_TX: port_id=DATA_PORT, write_strobe=1, out_port={8'h00, FIFO head}; pop. -> IDLE.
- Only one TX write per service pass. Remaining FIFO bytes go out on later passes triggered by the TXRDY rising-edge interrupt.
- Counters saturate at 8'hFF; never wrap.
- FIFO: DEPTH entries, log2(DEPTH)+1-bit pointers. Full and empty come from the pointer MSB compare. Push and pop never occur in the same cycle by construction.

## Timing
- Reset (async): state=IDLE, port_id=IDLE_PORT, out_port=0, all strobes and interrupt_ack 0, err_cnt=0, drop_cnt=0, FIFO empty, stat=0, last_byte=0.
- Reset mid-pass: abort immediately to reset values; in-flight byte lost.
- All outputs are registered. They assert in the cycle the FSM is in the named state.
- in_port is sampled in the same cycle read_strobe is high (combinational read path in the UART).
- interrupt to interrupt_ack: 1 cycle from IDLE.
- interrupt_ack to first read_strobe: 1 cycle.
- RX pass with echo: ACK, RD_STAT, RD_DATA, WR_LED, WR_TX = 5 cycles, then IDLE.
- interrupt still high (or re-set) in IDLE after a pass: a new pass starts the next cycle. Events arriving during a pass are therefore serviced, not lost.
- Between accesses port_id returns to IDLE_PORT, so it never aliases DATA_PORT or STAT_PORT.

## Configuration
- UART_ECHO_LED_EN defined: WR_LED state present as described.
- Undefined: WR_LED removed. RD_DATA branches directly using the WR_LED next-state rule. STAT_PORT is never written and err_cnt is still maintained.

## Test plan
- Reset, then interrupt=1 with status 8'h03 and data 8'hA5: interrupt_ack at cycle 1; read STAT_PORT; read DATA_PORT; write STAT_PORT with 16'h00A5; write DATA_PORT with 16'h00A5; back to IDLE; FIFO empty.
- Status 8'h01 (TXRDY low), bytes 8'h11, 8'h22: no TX write on either pass. A later interrupt with status 8'h02 writes 16'h0011, the next writes 16'h0022.
- Five RX passes with TXRDY=0 and DEPTH=4: drop_cnt=1; the fifth byte is never echoed; the first four drain in order.
- Status 8'h0D (PERR|FERR|RXRDY): err_cnt increments to 1; LED write high byte = 8'h01.
- Assert rst during RD_DATA: all outputs go to reset values asynchronously; the FIFO does not contain the byte.
- Build without UART_ECHO_LED_EN: no write_strobe with port_id=STAT_PORT ever; RX pass takes 4 cycles.

Source files
------------

// File: rtl/uart_echo_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_master
// Purpose  : Hardwired port-bus initiator standing in for the soft processor
//            in front of the UART core. On each UART interrupt it acknowledges,
//            reads status, reads an RX byte when one is ready, buffers it in a
//            small FIFO, optionally mirrors activity to the LED port, and echoes
//            at most one buffered byte per service pass.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            interrupt           - level from the UART interrupt flop
//            in_port[15:0]       - read data (status or RX byte)
//            port_id[15:0]       - access address (IDLE_PORT when idle)
//            out_port[15:0]      - write data
//            read_strobe         - one-cycle read qualifier
//            write_strobe        - one-cycle write qualifier
//            interrupt_ack       - one-cycle acknowledge pulse
//            err_cnt[7:0]        - saturating count of RX bytes with PERR/FERR/OVF
//            drop_cnt[7:0]       - saturating count of RX bytes dropped on full
// Config   : define UART_ECHO_LED_EN to include the LED write state (WR_LED).
// Revision : 1.0 - initial release
// ============================================================================
module uart_echo_master #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] DATA_PORT = 16'h0000,
  parameter logic [15:0] STAT_PORT = 16'h0001,
  parameter logic [15:0] IDLE_PORT = 16'h00FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt,
  input  logic [15:0] in_port,
  output logic [15:0] port_id,
  output logic [15:0] out_port,
  output logic        read_strobe,
  output logic        write_strobe,
  output logic        interrupt_ack,
  output logic [7:0]  err_cnt,
  output logic [7:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);

`ifdef UART_ECHO_LED_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_RD_STAT, S_RD_DATA, S_WR_TX, S_WR_LED
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_RD_STAT, S_RD_DATA, S_WR_TX
  } state_t;
`endif

  state_t state, next_state;

  // Status byte captured during RD_STAT; drives the decisions later in the pass
  logic [7:0] stat;

  // Echo FIFO: one extra pointer bit distinguishes full from empty
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full;
  logic        push, pop, drop, err_hit;
  logic [7:0]  rx_byte, err_nxt, tx_head;

  // Next values for the registered bus outputs
  logic [15:0] nx_port_id, nx_out_port;
  logic        nx_rd, nx_wr, nx_ack;

  // Bits of in_port/stat that carry no meaning for this initiator
  logic unused_bits;
  assign unused_bits = ^{in_port[15:8], stat[7:5], stat[0]};

  assign rx_byte    = in_port[7:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // RD_DATA is the only state that pushes and WR_TX the only one that pops,
  // so the two never coincide.
  assign push    = (state == S_RD_DATA) && !fifo_full;
  assign drop    = (state == S_RD_DATA) &&  fifo_full;
  assign pop     = (state == S_WR_TX)   && !fifo_empty;
  assign err_hit = (state == S_RD_DATA) && (|stat[4:2]);
  assign err_nxt = (err_hit && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;

  // When WR_TX follows RD_DATA directly with an empty FIFO, the byte being
  // pushed this cycle is the head; bypass it because memory is not yet written.
  assign tx_head = ((state == S_RD_DATA) && fifo_empty) ? rx_byte : mem[rd_ptr[AW-1:0]];

  // --------------------------------------------------------------------------
  // Next-state and next-output logic. Outputs are decoded from next_state and
  // registered, so each strobe is high exactly while the FSM sits in its state.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state  = state;
    nx_port_id  = IDLE_PORT;
    nx_out_port = 16'h0000;
    nx_rd       = 1'b0;
    nx_wr       = 1'b0;
    nx_ack      = 1'b0;

    case (state)
      S_IDLE:    if (interrupt) next_state = S_ACK;
      S_ACK:     next_state = S_RD_STAT;
      // Status is read combinationally here, so decide on in_port directly
      S_RD_STAT: begin
        if (rx_byte[0])                     next_state = S_RD_DATA;
        else if (rx_byte[1] && !fifo_empty) next_state = S_WR_TX;
        else                                next_state = S_IDLE;
      end
`ifdef UART_ECHO_LED_EN
      S_RD_DATA: next_state = S_WR_LED;
      S_WR_LED: begin
        if (stat[1] && !fifo_empty) next_state = S_WR_TX;
        else                        next_state = S_IDLE;
      end
`else
      S_RD_DATA: begin
        if (stat[1] && (!fifo_empty || push)) next_state = S_WR_TX;
        else                                  next_state = S_IDLE;
      end
`endif
      S_WR_TX:   next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase

    case (next_state)
      S_ACK:     nx_ack = 1'b1;
      S_RD_STAT: begin
        nx_port_id = STAT_PORT;
        nx_rd      = 1'b1;
      end
      S_RD_DATA: begin
        nx_port_id = DATA_PORT;
        nx_rd      = 1'b1;
      end
`ifdef UART_ECHO_LED_EN
      // Only reached from RD_DATA, so the updated error count and the byte on
      // in_port are the values this pass produced; out_port holds last_byte.
      S_WR_LED: begin
        nx_port_id  = STAT_PORT;
        nx_wr       = 1'b1;
        nx_out_port = {err_nxt, rx_byte};
      end
`endif
      S_WR_TX: begin
        nx_port_id  = DATA_PORT;
        nx_wr       = 1'b1;
        nx_out_port = {8'h00, tx_head};
      end
      default: ;
    endcase
  end

  // State and registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      port_id       <= IDLE_PORT;
      out_port      <= 16'h0000;
      read_strobe   <= 1'b0;
      write_strobe  <= 1'b0;
      interrupt_ack <= 1'b0;
    end else begin
      state         <= next_state;
      port_id       <= nx_port_id;
      out_port      <= nx_out_port;
      read_strobe   <= nx_rd;
      write_strobe  <= nx_wr;
      interrupt_ack <= nx_ack;
    end
  end

  // Status capture and saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat     <= 8'h00;
      err_cnt  <= 8'h00;
      drop_cnt <= 8'h00;
    end else begin
      if (state == S_RD_STAT) stat <= rx_byte;
      err_cnt <= err_nxt;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_echo_master
// Purpose  : Self-checking bench for uart_echo_master. A small UART model
//            answers reads; each service pass pushes its expected bus accesses
//            into a queue which a negedge monitor pops and compares.
//            Follows UART_ECHO_LED_EN for the LED-write expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_echo_master;

  localparam logic [15:0] DATA_P  = 16'h0000;
  localparam logic [15:0] STAT_P  = 16'h0001;
  localparam logic [15:0] IDLE_P  = 16'h00FF;
  localparam int          DEPTH_P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        interrupt = 1'b0;
  logic [15:0] in_port;
  logic [15:0] port_id, out_port;
  logic        read_strobe, write_strobe, interrupt_ack;
  logic [7:0]  err_cnt, drop_cnt;

  logic [7:0]  uart_stat = 8'h00;
  logic [7:0]  uart_data = 8'h00;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [15:0] port;
    logic [15:0] data;
  } bus_t;

  bus_t       exp_q[$];
  logic [7:0] mfifo[$];
  int         merr  = 0;
  int         mdrop = 0;

  always #5 clk = ~clk;

  // UART read path: combinational on port_id while read_strobe is high
  always_comb begin
    in_port = 16'h0000;
    if (read_strobe) begin
      if (port_id == STAT_P)      in_port = {8'h00, uart_stat};
      else if (port_id == DATA_P) in_port = {8'h00, uart_data};
    end
  end

  uart_echo_master #(
    .DEPTH(DEPTH_P), .DATA_PORT(DATA_P), .STAT_PORT(STAT_P), .IDLE_PORT(IDLE_P)
  ) dut (
    .clk(clk), .rst(rst), .interrupt(interrupt), .in_port(in_port),
    .port_id(port_id), .out_port(out_port), .read_strobe(read_strobe),
    .write_strobe(write_strobe), .interrupt_ack(interrupt_ack),
    .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bus_t mk(input logic wr, input logic [15:0] port, input logic [15:0] data);
    bus_t b;
    b.wr = wr; b.port = port; b.data = data;
    return b;
  endfunction

  // Monitor: every strobe must match the next queued access
  always @(negedge clk) begin
    if (!rst) begin
      if (read_strobe || write_strobe) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got wr=%0d port=%h data=%h expected no access",
                   write_strobe, port_id, out_port);
        end else begin
          bus_t e;
          e = exp_q.pop_front();
          check("bus_access", {write_strobe, port_id, (write_strobe ? out_port : 16'h0000)},
                {e.wr, e.port, e.data});
        end
      end else begin
        check("idle_port_id", {17'h0, port_id}, {17'h0, IDLE_P});
      end
    end
  end

  // Scoreboard model: queue the accesses one pass should make; return its length
  task automatic expect_pass(input logic [7:0] s, input logic [7:0] d, output int cyc);
    exp_q.push_back(mk(1'b0, STAT_P, 16'h0000));
    cyc = 2;
    if (s[0]) begin
      exp_q.push_back(mk(1'b0, DATA_P, 16'h0000));
      cyc++;
      if (mfifo.size() < DEPTH_P) mfifo.push_back(d);
      else if (mdrop != 255)      mdrop++;
      if ((|s[4:2]) && merr != 255) merr++;
`ifdef UART_ECHO_LED_EN
      exp_q.push_back(mk(1'b1, STAT_P, {merr[7:0], d}));
      cyc++;
`endif
    end
    if (s[1] && mfifo.size() > 0) begin
      exp_q.push_back(mk(1'b1, DATA_P, {8'h00, mfifo.pop_front()}));
      cyc++;
    end
  endtask

  task automatic do_pass(input logic [7:0] s, input logic [7:0] d);
    int  cyc, n, lat;
    bit  got, done;
    uart_stat = s;
    uart_data = d;
    expect_pass(s, d, cyc);
    @(negedge clk);
    interrupt = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (interrupt_ack) begin
        got = 1'b1;
        lat = i;
      end
    end
    interrupt = 1'b0;
    if (!got) begin
      check("ack_timeout", 33'd0, 33'd1);
      return;
    end
    check("ack_latency", 33'(lat), 33'd0);
    n = 1;
    done = 1'b0;
    for (int k = 0; k < 16 && !done; k++) begin
      @(negedge clk);
      if (read_strobe || write_strobe || interrupt_ack) n++;
      else done = 1'b1;
    end
    check("pass_cycles", 33'(n), 33'(cyc));
    check("queue_drained", 33'(exp_q.size()), 33'd0);
    check("err_cnt", {25'h0, err_cnt}, 33'(merr));
    check("drop_cnt", {25'h0, drop_cnt}, 33'(mdrop));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_port_id"},  {17'h0, port_id},  {17'h0, IDLE_P});
    check({tag, "_out_port"}, {17'h0, out_port}, 33'd0);
    check({tag, "_strobes"},  {30'h0, read_strobe, write_strobe, interrupt_ack}, 33'd0);
    check({tag, "_err_cnt"},  {25'h0, err_cnt},  33'd0);
    check({tag, "_drop_cnt"}, {25'h0, drop_cnt}, 33'd0);
  endtask

  initial begin
    bit hit;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic echo
    do_pass(8'h03, 8'hA5);
    do_pass(8'h02, 8'h00);   // FIFO empty: status read only

    // Buffer while TXRDY is low, drain on later passes
    do_pass(8'h01, 8'h11);
    do_pass(8'h01, 8'h22);
    do_pass(8'h02, 8'h00);
    do_pass(8'h02, 8'h00);
    do_pass(8'h02, 8'h00);

    // Overflow the four-entry FIFO
    for (int i = 0; i < 5; i++) do_pass(8'h01, 8'(8'h31 + i));
    check("drop_after_five", {25'h0, drop_cnt}, 33'd1);
    for (int i = 0; i < 5; i++) do_pass(8'h02, 8'h00);

    // Error flags
    do_pass(8'h0D, 8'h5A);
    check("err_after_perr_ferr", {25'h0, err_cnt}, 33'd1);
    do_pass(8'h02, 8'h00);
    do_pass(8'h13, 8'h6B);

    // Asynchronous reset in the middle of RD_DATA
    do_pass(8'h01, 8'h44);   // leave one byte buffered too
    uart_stat = 8'h01;
    uart_data = 8'h77;
    exp_q.push_back(mk(1'b0, STAT_P, 16'h0000));
    exp_q.push_back(mk(1'b0, DATA_P, 16'h0000));
    @(negedge clk);
    interrupt = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      if (interrupt_ack) interrupt = 1'b0;
      if (read_strobe && port_id == DATA_P) hit = 1'b1;
    end
    check("reach_rd_data", {32'h0, hit}, 33'd1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    interrupt = 1'b0;
    exp_q.delete();
    mfifo.delete();
    merr  = 0;
    mdrop = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_pass(8'h02, 8'h00);   // FIFO must be empty after reset
    do_pass(8'h03, 8'hC3);

    // Saturation of both counters
    for (int i = 0; i < 262; i++) do_pass(8'h1D, 8'(i));
    check("err_saturated",  {25'h0, err_cnt},  33'h0FF);
    check("drop_saturated", {25'h0, drop_cnt}, 33'h0FF);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
